// File: rtl/env_pkg.sv
// Shared constants and state encoding for the ADSR envelope and per-sample helpers.
package env_pkg;

    localparam int TICK_DIV_DEF = 500;
    localparam int LEVEL_W_DEF  = 24;

    localparam logic [LEVEL_W_DEF-1:0] LEVEL_MAX = {LEVEL_W_DEF{1'b1}};

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } env_state_e;

endpackage

// File: rtl/tick_gen.sv
// Free-running divider: one-cycle tick every TICK_DIV clk24 cycles.
module tick_gen #(
    parameter int TICK_DIV = env_pkg::TICK_DIV_DEF
) (
    input  logic clk24,
    input  logic rst,
    output logic tick
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end

    assign tick = (cnt_q == LAST);

    always_ff @(posedge clk24) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/env_adsr.sv
// Linear ADSR envelope for one FM operator; level steps once per sample tick,
// gate edges retarget the state immediately and keep the current level.
module env_adsr
    import env_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEF,
    parameter int LEVEL_W  = LEVEL_W_DEF
) (
    input  logic        clk24,
    input  logic        rst,
    input  logic        trig,
    input  logic [15:0] attack_rate,
    input  logic [15:0] decay_rate,
    input  logic [15:0] sustain_level,
    input  logic [15:0] release_rate,
    output logic [15:0] amplitude,
    output logic        active,
    output logic [2:0]  env_state
);

    localparam logic [LEVEL_W-1:0] LVL_MAX = {LEVEL_W{1'b1}};

    logic               tick;
    logic               trig_d_q;
    logic               rise, fall;
    env_state_e         state_q, state_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic [LEVEL_W-1:0] s_lvl;
    logic [LEVEL_W:0]   sum_a, diff_d, diff_r;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk24 (clk24),
        .rst   (rst),
        .tick  (tick)
    );

    assign rise  = trig & ~trig_d_q;
    assign fall  = ~trig & trig_d_q;
    assign s_lvl = LEVEL_W'(sustain_level) << (LEVEL_W - 16);

    // One extra bit exposes attack overflow and decay/release borrow.
    assign sum_a  = {1'b0, level_q} + (LEVEL_W+1)'(attack_rate);
    assign diff_d = {1'b0, level_q} - (LEVEL_W+1)'(decay_rate);
    assign diff_r = {1'b0, level_q} - (LEVEL_W+1)'(release_rate);

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        if (rise) begin
            state_d = ATTACK;
        end else if (fall) begin
            if (state_q inside {ATTACK, DECAY, SUSTAIN}) state_d = RELEASE;
        end else if (tick) begin
            case (state_q)
                ATTACK: begin
                    if (attack_rate == '0 || sum_a[LEVEL_W] || sum_a[LEVEL_W-1:0] == LVL_MAX) begin
                        level_d = LVL_MAX;
                        state_d = DECAY;
                    end else begin
                        level_d = sum_a[LEVEL_W-1:0];
                    end
                end
                DECAY: begin
                    // Also covers a sustain level raised above the current level.
                    if (decay_rate == '0 || level_q <= s_lvl || diff_d[LEVEL_W]
                        || diff_d[LEVEL_W-1:0] <= s_lvl) begin
                        level_d = s_lvl;
                        state_d = SUSTAIN;
                    end else begin
                        level_d = diff_d[LEVEL_W-1:0];
                    end
                end
                SUSTAIN: level_d = s_lvl;
                RELEASE: begin
                    if (release_rate == '0 || diff_r[LEVEL_W] || diff_r[LEVEL_W-1:0] == '0) begin
                        level_d = '0;
                        state_d = IDLE;
                    end else begin
                        level_d = diff_r[LEVEL_W-1:0];
                    end
                end
                default: begin
                    level_d = '0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk24) begin
        if (rst) begin
            state_q  <= IDLE;
            level_q  <= '0;
            trig_d_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            level_q  <= level_d;
            trig_d_q <= trig;
        end
    end

    assign amplitude = level_q[LEVEL_W-1 -: 16];
    assign active    = (state_q != IDLE);
    assign env_state = state_q;

endmodule

// File: tb/tb_env_adsr.sv
// Scoreboard bench for env_adsr at TICK_DIV=4: expectations queued with stimulus, checked at output points.
module tb_env_adsr;
    import env_pkg::*;

    localparam int TD = 4;

    logic        clk24 = 1'b0;
    logic        rst   = 1'b1;
    logic        trig  = 1'b0;
    logic [15:0] ar = '0, dr = '0, sl = '0, rr = '0;
    logic [15:0] amplitude;
    logic        active;
    logic [2:0]  env_state;

    int n_tests = 0;
    int n_fail  = 0;
    int tcnt;

    string       tag_q[$];
    logic [19:0] exp_q[$];

    env_adsr #(.TICK_DIV(TD), .LEVEL_W(24)) dut (
        .clk24         (clk24),
        .rst           (rst),
        .trig          (trig),
        .attack_rate   (ar),
        .decay_rate    (dr),
        .sustain_level (sl),
        .release_rate  (rr),
        .amplitude     (amplitude),
        .active        (active),
        .env_state     (env_state)
    );

    always #5 clk24 = ~clk24;

    // Bench-side sample-tick reference: the tick closes on the edge leaving TD-1.
    always @(posedge clk24) begin
        if (rst) tcnt <= 0;
        else     tcnt <= (tcnt == TD-1) ? 0 : tcnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [15:0] a, input logic [2:0] s, input logic act);
        tag_q.push_back(tag);
        exp_q.push_back({act, s, a});
    endtask

    task automatic pop_check();
        string       t;
        logic [19:0] e;
        if (tag_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard: got empty queue want entry");
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            chk({t, "_amp"},    32'(amplitude), 32'(e[15:0]));
            chk({t, "_state"},  32'(env_state), 32'(e[18:16]));
            chk({t, "_active"}, 32'(active),    32'(e[19]));
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk24);
        #1;
    endtask

    // Waits for n tick-closing edges, then settles 1 time unit past the last one.
    task automatic tick_wait(input int n);
        int t;
        repeat (n) begin
            do begin
                @(negedge clk24);
                t = tcnt;
                @(posedge clk24);
            end while (t != TD-1);
        end
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc(3);
        expect_out("reset", 16'h0, IDLE, 1'b0);
        pop_check();
        rst = 1'b0;
        ar = 16'h8000; dr = 16'h8000; sl = 16'h8000; rr = 16'h1000;
        expect_out("idle_tick", 16'h0, IDLE, 1'b0);
        tick_wait(1);
        pop_check();

        // Attack ramp to full scale, then decay into sustain.
        trig = 1'b1;
        expect_out("rise", 16'h0, ATTACK, 1'b1);
        cyc(1); pop_check();
        expect_out("att511", 16'hFF80, ATTACK, 1'b1);
        tick_wait(511); pop_check();
        expect_out("att512", 16'hFFFF, DECAY, 1'b1);
        tick_wait(1); pop_check();
        expect_out("dec255", 16'h807F, DECAY, 1'b1);
        tick_wait(255); pop_check();
        expect_out("dec256", 16'h8000, SUSTAIN, 1'b1);
        tick_wait(1); pop_check();
        sl = 16'h4000;
        expect_out("sus_lower", 16'h4000, SUSTAIN, 1'b1);
        tick_wait(1); pop_check();
        sl = 16'h8000;
        expect_out("sus_raise", 16'h8000, SUSTAIN, 1'b1);
        tick_wait(1); pop_check();

        // Full release from 0x8000.
        trig = 1'b0;
        expect_out("fall", 16'h8000, RELEASE, 1'b1);
        cyc(1); pop_check();
        expect_out("rel2047", 16'h0010, RELEASE, 1'b1);
        tick_wait(2047); pop_check();
        expect_out("rel2048", 16'h0000, IDLE, 1'b0);
        tick_wait(1); pop_check();

        // Retrigger during release keeps the current level.
        ar = 16'h0; dr = 16'h0;
        trig = 1'b1;
        expect_out("inst_rise", 16'h0, ATTACK, 1'b1);
        cyc(1); pop_check();
        expect_out("inst_att", 16'hFFFF, DECAY, 1'b1);
        tick_wait(1); pop_check();
        expect_out("inst_dec", 16'h8000, SUSTAIN, 1'b1);
        tick_wait(1); pop_check();
        trig = 1'b0;
        expect_out("fall2", 16'h8000, RELEASE, 1'b1);
        cyc(1); pop_check();
        expect_out("rel1535", 16'h2010, RELEASE, 1'b1);
        tick_wait(1535); pop_check();
        expect_out("rel1536", 16'h2000, RELEASE, 1'b1);
        tick_wait(1); pop_check();
        ar = 16'h0100;
        trig = 1'b1;
        expect_out("retrig", 16'h2000, ATTACK, 1'b1);
        cyc(1); pop_check();
        expect_out("retrig_tick", 16'h2001, ATTACK, 1'b1);
        tick_wait(1); pop_check();

        // All rates zero.
        ar = 16'h0; dr = 16'h0; rr = 16'h0; sl = 16'h1234;
        expect_out("z_att", 16'hFFFF, DECAY, 1'b1);
        tick_wait(1); pop_check();
        expect_out("z_dec", 16'h1234, SUSTAIN, 1'b1);
        tick_wait(1); pop_check();
        trig = 1'b0;
        expect_out("z_fall", 16'h1234, RELEASE, 1'b1);
        cyc(1); pop_check();
        expect_out("z_rel", 16'h0, IDLE, 1'b0);
        tick_wait(1); pop_check();

        // One-cycle gate pulse.
        rr = 16'h1000;
        trig = 1'b1;
        expect_out("pulse_rise", 16'h0, ATTACK, 1'b1);
        cyc(1); pop_check();
        trig = 1'b0;
        expect_out("pulse_fall", 16'h0, RELEASE, 1'b1);
        cyc(1); pop_check();
        expect_out("pulse_idle", 16'h0, IDLE, 1'b0);
        tick_wait(1); pop_check();

        // Zero sustain level still reports active.
        sl = 16'h0;
        trig = 1'b1;
        cyc(1);
        expect_out("sus0", 16'h0, SUSTAIN, 1'b1);
        tick_wait(2); pop_check();
        trig = 1'b0;
        cyc(1);
        expect_out("sus0_rel", 16'h0, IDLE, 1'b0);
        tick_wait(1); pop_check();

        // Reset mid-attack with the gate still held.
        ar = 16'h8000;
        trig = 1'b1;
        cyc(1);
        expect_out("att3", 16'h0180, ATTACK, 1'b1);
        tick_wait(3); pop_check();
        rst = 1'b1;
        expect_out("mid_rst", 16'h0, IDLE, 1'b0);
        cyc(1); pop_check();
        rst = 1'b0;
        expect_out("post_rst", 16'h0, ATTACK, 1'b1);
        cyc(1); pop_check();
        expect_out("post_rst_tick", 16'h0080, ATTACK, 1'b1);
        tick_wait(1); pop_check();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
